// File: rtl/pc_ctrl_pkg.sv
// Shared types for the pc redirect sequencer: FSM states, redirect kinds, arbitration order.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StRun   = 2'd1,
    StIssue = 2'd2,
    StFlush = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    KindTrap = 2'd0,
    KindBr   = 2'd1,
    KindRet  = 2'd2
  } kind_e;

  localparam int unsigned NumReq = 3;
  // Request bit positions; the lowest index has the highest priority.
  localparam int unsigned PrioTrap = 0;
  localparam int unsigned PrioBr   = 1;
  localparam int unsigned PrioRet  = 2;

  // Shared boot/flush down-counter width (BOOT_DELAY up to 15).
  localparam int unsigned CntW = 4;

  // Encode a one-hot (or empty) grant vector into a redirect kind.
  function automatic kind_e kind_from_grant(input logic [NumReq-1:0] grant);
    kind_e k;
    k = KindTrap;
    if (grant[PrioBr])  k = KindBr;
    if (grant[PrioRet]) k = KindRet;
    return k;
  endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Fixed-priority arbiter over trap/branch/return requests: one-hot grant plus encoded kind.
module pc_redirect_arb
  import pc_ctrl_pkg::*;
(
  input  logic [NumReq-1:0] i_req,
  output logic [NumReq-1:0] o_grant,
  output logic              o_valid,
  output kind_e             o_kind
);

  // Grant the highest-priority active request only.
  always_comb begin
    o_grant = '0;
    if (i_req[PrioTrap]) begin
      o_grant[PrioTrap] = 1'b1;
    end else if (i_req[PrioBr]) begin
      o_grant[PrioBr] = 1'b1;
    end else if (i_req[PrioRet]) begin
      o_grant[PrioRet] = 1'b1;
    end
    o_valid = |i_req;
    o_kind  = kind_from_grant(o_grant);
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Sequencer in front of the pc register: boot stall, redirect arbitration, single-cycle
// br/ret load pulses, stall merging and IF/ID flush windows.
module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned BOOT_DELAY   = 2,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter bit          RET_VIA_BR   = 1'b1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_trap_valid,
  input  logic [XLEN-1:0] i_trap_vec,
  input  logic            i_br_valid,
  input  logic [XLEN-1:0] i_br_target,
  input  logic            i_ret_valid,
  input  logic [XLEN-1:0] i_ret_target,
  input  logic            i_hazard_stall,
  input  logic            i_imem_ready,
  output logic            o_trap_ack,
  output logic            o_br_ack,
  output logic            o_ret_ack,
  output logic            o_br_ctrl,
  output logic [XLEN-1:0] o_br_addr,
  output logic            o_ret_ctrl,
  output logic [XLEN-1:0] o_ret_pc,
  output logic            o_pc_stall,
  output logic            o_flush_if,
  output logic            o_flush_id,
  output logic            o_misalign,
  output logic [15:0]     o_redirect_cnt
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CntW-1:0]   r_cnt;
  logic [CntW-1:0]   w_cnt_nxt;
  logic [XLEN-1:0]   r_target;
  kind_e             r_kind;
  logic              r_misalign;
  logic [XLEN-1:0]   r_br_addr;
  logic [XLEN-1:0]   r_ret_pc;
  logic [15:0]       r_redirect_cnt;

  logic [NumReq-1:0] w_req;
  logic [NumReq-1:0] w_grant;
  logic              w_accept;
  kind_e             w_kind;
  logic [XLEN-1:0]   w_sel_target;
  logic              w_fire;
  logic              w_fire_br;
  logic              w_fire_ret;
  logic              w_pc_stall;
  logic              w_flush_if;
  logic              w_flush_id;

  // RUN arbitrates all requests; FLUSH only lets a trap through; BOOT/ISSUE accept nothing.
  assign w_req[PrioTrap] = i_trap_valid & ((r_state == StRun) | (r_state == StFlush));
  assign w_req[PrioBr]   = i_br_valid & (r_state == StRun);
  assign w_req[PrioRet]  = i_ret_valid & (r_state == StRun);

  pc_redirect_arb u_arb (
    .i_req   (w_req),
    .o_grant (w_grant),
    .o_valid (w_accept),
    .o_kind  (w_kind)
  );

  // Pick the raw target belonging to the granted request.
  always_comb begin
    w_sel_target = i_ret_target;
    if (w_grant[PrioTrap]) begin
      w_sel_target = i_trap_vec;
    end else if (w_grant[PrioBr]) begin
      w_sel_target = i_br_target;
    end
  end

  assign w_fire     = (r_state == StIssue) & i_imem_ready;
  assign w_fire_ret = w_fire & (r_kind == KindRet) & ~RET_VIA_BR;
  assign w_fire_br  = w_fire & ~w_fire_ret;

  // Next-state, counter and stall/flush decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pc_stall  = 1'b0;
    w_flush_if  = 1'b0;
    w_flush_id  = 1'b0;
    unique case (r_state)
      StBoot: begin
        w_pc_stall = 1'b1;
        if (r_cnt <= CntW'(1)) begin
          w_state_nxt = StRun;
        end else begin
          w_cnt_nxt = r_cnt - CntW'(1);
        end
      end
      StRun: begin
        w_pc_stall = i_hazard_stall | ~i_imem_ready;
        if (w_accept) begin
          w_state_nxt = StIssue;
        end
      end
      StIssue: begin
        if (i_imem_ready) begin
          // Redirect beats any hazard stall in the fire cycle.
          w_flush_if  = 1'b1;
          w_state_nxt = StFlush;
          w_cnt_nxt   = CntW'(FLUSH_CYCLES);
        end else begin
          w_pc_stall = 1'b1;
        end
      end
      StFlush: begin
        w_flush_if = 1'b1;
        w_flush_id = 1'b1;
        w_pc_stall = i_hazard_stall | ~i_imem_ready;
        if (w_accept) begin
          w_state_nxt = StIssue;
        end else if (r_cnt <= CntW'(1)) begin
          w_state_nxt = StRun;
        end else begin
          w_cnt_nxt = r_cnt - CntW'(1);
        end
      end
      default: begin
        w_state_nxt = StBoot;
      end
    endcase
  end

  // State register and shared boot/flush counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= StBoot;
      r_cnt   <= CntW'(BOOT_DELAY);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Latched redirect, last-issued addresses and saturating redirect count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_target       <= '0;
      r_kind         <= KindTrap;
      r_misalign     <= 1'b0;
      r_br_addr      <= '0;
      r_ret_pc       <= '0;
      r_redirect_cnt <= '0;
    end else begin
      r_misalign <= w_accept & (|w_sel_target[1:0]);
      if (w_accept) begin
        r_target <= {w_sel_target[XLEN-1:2], 2'b00};
        r_kind   <= w_kind;
      end
      if (w_fire_br) begin
        r_br_addr <= r_target;
      end
      if (w_fire_ret) begin
        r_ret_pc <= r_target;
      end
      if (w_fire && (r_redirect_cnt != 16'hFFFF)) begin
        r_redirect_cnt <= r_redirect_cnt + 16'd1;
      end
    end
  end

  assign o_trap_ack     = w_grant[PrioTrap];
  assign o_br_ack       = w_grant[PrioBr];
  assign o_ret_ack      = w_grant[PrioRet];
  assign o_br_ctrl      = w_fire_br;
  assign o_ret_ctrl     = w_fire_ret;
  // Addresses show the new target during the pulse and hold it afterwards.
  assign o_br_addr      = w_fire_br ? r_target : r_br_addr;
  assign o_ret_pc       = w_fire_ret ? r_target : r_ret_pc;
  assign o_pc_stall     = w_pc_stall;
  assign o_flush_if     = w_flush_if;
  assign o_flush_id     = w_flush_id;
  assign o_misalign     = r_misalign;
  assign o_redirect_cnt = r_redirect_cnt;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios plus randomized requesters,
// all compared every cycle against a transaction-level reference model.
module tb_pc_redirect_ctrl;

  localparam int unsigned BootD  = 2;
  localparam int unsigned FlushC = 2;
  localparam bit          Rvb    = 1'b1;

  logic        clk;
  logic        rstn;
  logic        trap_v, br_v, ret_v, hazard, imem;
  logic [31:0] trap_vec, br_tgt, ret_tgt;
  logic        trap_ack, br_ack, ret_ack, br_ctrl, ret_ctrl;
  logic [31:0] br_addr, ret_pc;
  logic        pc_stall, flush_if, flush_id, misalign;
  logic [15:0] redirect_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pc_redirect_ctrl #(
    .XLEN         (32),
    .BOOT_DELAY   (BootD),
    .FLUSH_CYCLES (FlushC),
    .RET_VIA_BR   (Rvb)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_trap_valid   (trap_v),
    .i_trap_vec     (trap_vec),
    .i_br_valid     (br_v),
    .i_br_target    (br_tgt),
    .i_ret_valid    (ret_v),
    .i_ret_target   (ret_tgt),
    .i_hazard_stall (hazard),
    .i_imem_ready   (imem),
    .o_trap_ack     (trap_ack),
    .o_br_ack       (br_ack),
    .o_ret_ack      (ret_ack),
    .o_br_ctrl      (br_ctrl),
    .o_br_addr      (br_addr),
    .o_ret_ctrl     (ret_ctrl),
    .o_ret_pc       (ret_pc),
    .o_pc_stall     (pc_stall),
    .o_flush_if     (flush_if),
    .o_flush_id     (flush_id),
    .o_misalign     (misalign),
    .o_redirect_cnt (redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a pending redirect transaction plus boot/flush cycle budgets.
  int          m_boot_left;
  int          m_flush_left;
  bit          m_pend;
  logic [31:0] m_tgt;
  int          m_kind;   // 0 trap, 1 branch, 2 return
  logic [31:0] m_last_br, m_last_ret;
  int          m_cnt;
  bit          m_mis;

  // Expected values of the current cycle, also used to steer the requesters.
  bit          e_trap_ack, e_br_ack, e_ret_ack, e_fire, e_flush_id;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot_left  = BootD;
    m_flush_left = 0;
    m_pend       = 1'b0;
    m_tgt        = '0;
    m_kind       = 0;
    m_last_br    = '0;
    m_last_ret   = '0;
    m_cnt        = 0;
    m_mis        = 1'b0;
  endtask

  task automatic compare_all();
    bit booting, flushing, running, via_br, e_br_ctrl, e_ret_ctrl, e_stall;
    booting  = (m_boot_left > 0);
    flushing = !booting && !m_pend && (m_flush_left > 0);
    running  = !booting && !m_pend && !flushing;
    e_trap_ack = (running || flushing) && trap_v;
    e_br_ack   = running && !trap_v && br_v;
    e_ret_ack  = running && !trap_v && !br_v && ret_v;
    e_fire     = !booting && m_pend && imem;
    via_br     = (m_kind != 2) || Rvb;
    e_br_ctrl  = e_fire && via_br;
    e_ret_ctrl = e_fire && !via_br;
    e_flush_id = flushing;
    if (booting)     e_stall = 1'b1;
    else if (m_pend) e_stall = !imem;
    else             e_stall = hazard || !imem;
    check("trap_ack", 32'(trap_ack), 32'(e_trap_ack));
    check("br_ack", 32'(br_ack), 32'(e_br_ack));
    check("ret_ack", 32'(ret_ack), 32'(e_ret_ack));
    check("br_ctrl", 32'(br_ctrl), 32'(e_br_ctrl));
    check("ret_ctrl", 32'(ret_ctrl), 32'(e_ret_ctrl));
    check("br_addr", br_addr, e_br_ctrl ? m_tgt : m_last_br);
    check("ret_pc", ret_pc, e_ret_ctrl ? m_tgt : m_last_ret);
    check("pc_stall", 32'(pc_stall), 32'(e_stall));
    check("flush_if", 32'(flush_if), 32'(e_fire || flushing));
    check("flush_id", 32'(flush_id), 32'(flushing));
    check("misalign", 32'(misalign), 32'(m_mis));
    check("redirect_cnt", 32'(redirect_cnt), 32'(m_cnt));
  endtask

  task automatic model_step();
    logic [31:0] raw;
    bit          acc;
    acc   = e_trap_ack || e_br_ack || e_ret_ack;
    raw   = e_trap_ack ? trap_vec : (e_br_ack ? br_tgt : ret_tgt);
    m_mis = 1'b0;
    if (m_boot_left > 0) begin
      m_boot_left--;
    end else if (m_pend) begin
      if (e_fire) begin
        if ((m_kind != 2) || Rvb) m_last_br = m_tgt;
        else                      m_last_ret = m_tgt;
        if (m_cnt < 65535) m_cnt++;
        m_pend       = 1'b0;
        m_flush_left = FlushC;
      end
    end else begin
      if (m_flush_left > 0) m_flush_left--;
      if (acc) begin
        m_pend       = 1'b1;
        m_tgt        = raw & ~32'd3;
        m_kind       = e_trap_ack ? 0 : (e_br_ack ? 1 : 2);
        m_flush_left = 0;
        m_mis        = (raw[1:0] != 2'b00);
      end
    end
  endtask

  // One clock: compare just before the falling edge's settle point, then advance the model.
  task automatic cycle();
    @(negedge clk);
    compare_all();
    if (rstn) model_step();
    else      model_reset();
    @(posedge clk);
    #1;
  endtask

  // Requester protocol: trap holds until acked; br/ret hold until acked or flushed.
  task automatic update_reqs(input bit allow_new);
    if (!(trap_v && !e_trap_ack)) begin
      trap_v = allow_new && ($urandom_range(15) == 0);
      if (trap_v) trap_vec = $urandom;
    end
    if (!(br_v && !e_br_ack && !e_flush_id)) begin
      br_v = allow_new && ($urandom_range(3) == 0);
      if (br_v) br_tgt = $urandom;
    end
    if (!(ret_v && !e_ret_ack && !e_flush_id)) begin
      ret_v = allow_new && ($urandom_range(5) == 0);
      if (ret_v) ret_tgt = $urandom;
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      update_reqs(1'b0);
    end
  endtask

  initial begin
    rstn = 1'b0; trap_v = 1'b0; br_v = 1'b0; ret_v = 1'b0;
    hazard = 1'b0; imem = 1'b1;
    trap_vec = '0; br_tgt = '0; ret_tgt = '0;
    e_trap_ack = 1'b0; e_br_ack = 1'b0; e_ret_ack = 1'b0; e_fire = 1'b0; e_flush_id = 1'b0;
    model_reset();
    #1;
    run_cycles(3);

    // Boot: two stalled cycles, then running; a trap raised during boot must wait.
    rstn = 1'b1;
    trap_v = 1'b1; trap_vec = 32'h0000_0040;
    run_cycles(8);

    // Plain branch to 0x100.
    br_v = 1'b1; br_tgt = 32'h0000_0100;
    run_cycles(5);

    // Trap and branch together: trap wins, branch is dropped on flush_id.
    trap_v = 1'b1; trap_vec = 32'h0000_0080;
    br_v = 1'b1; br_tgt = 32'h0000_0300;
    run_cycles(6);

    // Misaligned return held in ISSUE by imem backpressure for three cycles.
    ret_v = 1'b1; ret_tgt = 32'h0000_0206;
    cycle(); update_reqs(1'b0);
    imem = 1'b0;
    run_cycles(3);
    imem = 1'b1;
    run_cycles(4);

    // Hazard stall during the fire cycle loses to the redirect.
    hazard = 1'b1;
    br_v = 1'b1; br_tgt = 32'h0000_0044;
    run_cycles(5);
    hazard = 1'b0;

    // Trap arriving inside the flush window restarts it.
    br_v = 1'b1; br_tgt = 32'h0000_0400;
    run_cycles(2);
    trap_v = 1'b1; trap_vec = 32'h0000_0013;
    run_cycles(6);

    // Asynchronous reset while a redirect waits in ISSUE.
    br_v = 1'b1; br_tgt = 32'h0000_0500;
    cycle(); update_reqs(1'b0);
    imem = 1'b0;
    cycle(); update_reqs(1'b0);
    rstn = 1'b0;
    model_reset();
    #1;
    compare_all();
    br_v = 1'b0; trap_v = 1'b0; ret_v = 1'b0;
    imem = 1'b1;
    run_cycles(2);
    rstn = 1'b1;
    run_cycles(6);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      hazard = ($urandom_range(3) == 0);
      imem   = ($urandom_range(4) != 0);
      cycle();
      update_reqs(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
